// File: rtl/sysid_qsys_reader.sv
// Avalon-MM read master that fetches the system-ID and build-timestamp words,
// compares them against the expected build and reports a held pass/fail result.
module sysid_qsys_reader #(
  parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TS    = 32'h571256B6,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  localparam logic [15:0] WaitLast = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  LatLast  = 3'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);

  typedef enum logic [2:0] {StIdle, StRdId, StLatId, StRdTs, StLatTs, StDone} state_e;

  state_e      state_q, state_d;
  logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic        id_match_q, id_match_d, ts_match_q, ts_match_d, timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d, ts_value_q, ts_value_d;
  logic        avm_read_q, avm_read_d, avm_address_q, avm_address_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic        capture;

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    pass_d        = pass_q;
    id_match_d    = id_match_q;
    ts_match_d    = ts_match_q;
    timeout_d     = timeout_q;
    id_value_d    = id_value_q;
    ts_value_d    = ts_value_q;
    avm_read_d    = avm_read_q;
    avm_address_d = avm_address_q;
    wait_cnt_d    = wait_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    capture       = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d       = StRdId;
          busy_d        = 1'b1;
          pass_d        = 1'b0;
          id_match_d    = 1'b0;
          ts_match_d    = 1'b0;
          timeout_d     = 1'b0;
          id_value_d    = '0;
          ts_value_d    = '0;
          avm_read_d    = 1'b1;
          avm_address_d = 1'b0;
          wait_cnt_d    = '0;
        end
      end
      StRdId, StRdTs: begin
        if (!avm_waitrequest) begin
          wait_cnt_d    = '0;
          avm_read_d    = 1'b0;
          avm_address_d = 1'b0;
          if (READ_LATENCY == 0) begin
            capture = 1'b1;
          end else begin
            lat_cnt_d = '0;
            state_d   = (state_q == StRdId) ? StLatId : StLatTs;
          end
        end else if (wait_cnt_q == WaitLast) begin
          timeout_d     = 1'b1;
          avm_read_d    = 1'b0;
          avm_address_d = 1'b0;
          state_d       = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      StLatId, StLatTs: begin
        if (lat_cnt_q == LatLast) begin
          capture = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Capture both updates the held word and its match flag in the same edge.
    if (capture) begin
      if (state_q == StRdId || state_q == StLatId) begin
        id_value_d    = avm_readdata;
        id_match_d    = (avm_readdata == EXPECTED_ID);
        state_d       = StRdTs;
        avm_read_d    = 1'b1;
        avm_address_d = 1'b1;
        wait_cnt_d    = '0;
      end else begin
        ts_value_d = avm_readdata;
        ts_match_d = (avm_readdata == EXPECTED_TS);
        state_d    = StDone;
      end
    end

    if (state_d == StDone && state_q != StDone) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      pass_d = id_match_d & ts_match_d & ~timeout_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      id_match_q    <= 1'b0;
      ts_match_q    <= 1'b0;
      timeout_q     <= 1'b0;
      id_value_q    <= '0;
      ts_value_q    <= '0;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      wait_cnt_q    <= '0;
      lat_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      id_match_q    <= id_match_d;
      ts_match_q    <= ts_match_d;
      timeout_q     <= timeout_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      wait_cnt_q    <= wait_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_match    = id_match_q;
  assign ts_match    = ts_match_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;

endmodule

// File: tb/tb_sysid_qsys_reader.sv
// Bench for sysid_qsys_reader: two instances (zero latency / short timeout, and
// two-cycle latency with a stalling slave), scoreboard checked on each done pulse.
module tb_sysid_qsys_reader;

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        pass;
    logic        idm;
    logic        tsm;
    logic        to;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic exp_t mk(input logic [31:0] id, input logic [31:0] ts, input logic p,
                              input logic im, input logic tm, input logic to, input int c);
    exp_t e;
    e.id = id; e.ts = ts; e.pass = p; e.idm = im; e.tsm = tm; e.to = to; e.cyc = c;
    return e;
  endfunction

  // Instance A: READ_LATENCY=0, TIMEOUT_CYCLES=4, combinational slave.
  logic        rst_a, start_a, busy_a, done_a, pass_a, idm_a, tsm_a, to_a;
  logic [31:0] idv_a, tsv_a, rd_a, slv_id_a, slv_ts_a;
  logic        addr_a, read_a, wr_a;
  assign rd_a = addr_a ? slv_ts_a : slv_id_a;

  sysid_qsys_reader #(
    .EXPECTED_ID(32'hACD51302), .EXPECTED_TS(32'h571256B6),
    .READ_LATENCY(0), .TIMEOUT_CYCLES(4)
  ) u_dut_a (
    .clock(clk), .reset(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .id_match(idm_a), .ts_match(tsm_a), .timeout(to_a),
    .id_value(idv_a), .ts_value(tsv_a), .avm_address(addr_a), .avm_read(read_a),
    .avm_readdata(rd_a), .avm_waitrequest(wr_a)
  );

  // Instance B: READ_LATENCY=2, slave stalls 3 cycles per read and drives data
  // only in the cycle exactly two edges after accept.
  logic        rst_b, start_b, busy_b, done_b, pass_b, idm_b, tsm_b, to_b;
  logic [31:0] idv_b, tsv_b, rd_b;
  logic        addr_b, read_b, wr_b;
  logic [1:0]  bst = 2'd0;
  logic [1:0]  blat = 2'd0;
  logic        baddr = 1'b0;
  assign wr_b = read_b && (bst != 2'd3);
  assign rd_b = (blat == 2'd1) ? (baddr ? 32'h571256B6 : 32'hACD51302) : 32'hDEADBEEF;
  always @(posedge clk) begin
    if (read_b && wr_b) begin
      bst <= bst + 2'd1;
    end else if (read_b) begin
      bst   <= 2'd0;
      blat  <= 2'd2;
      baddr <= addr_b;
    end else if (blat != 2'd0) begin
      blat <= blat - 2'd1;
    end
  end

  sysid_qsys_reader #(
    .EXPECTED_ID(32'hACD51302), .EXPECTED_TS(32'h571256B6),
    .READ_LATENCY(2), .TIMEOUT_CYCLES(255)
  ) u_dut_b (
    .clock(clk), .reset(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .id_match(idm_b), .ts_match(tsm_b), .timeout(to_b),
    .id_value(idv_b), .ts_value(tsv_b), .avm_address(addr_b), .avm_read(read_b),
    .avm_readdata(rd_b), .avm_waitrequest(wr_b)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  int   dones_a = 0;
  int   dones_b = 0;

  always @(negedge clk) begin
    if (done_a) begin
      exp_t e;
      dones_a++;
      if (q_a.size() == 0) begin
        chk("A unexpected done", 32'd1, 32'd0);
      end else begin
        e = q_a.pop_front();
        chk("A done cycle", 32'(cyc), 32'(e.cyc));
        chk("A flags {busy,pass,idm,tsm,to}", {27'd0, busy_a, pass_a, idm_a, tsm_a, to_a},
            {27'd0, 1'b0, e.pass, e.idm, e.tsm, e.to});
        chk("A id_value", idv_a, e.id);
        chk("A ts_value", tsv_a, e.ts);
      end
    end
    if (done_b) begin
      exp_t e;
      dones_b++;
      if (q_b.size() == 0) begin
        chk("B unexpected done", 32'd1, 32'd0);
      end else begin
        e = q_b.pop_front();
        chk("B done cycle", 32'(cyc), 32'(e.cyc));
        chk("B flags {busy,pass,idm,tsm,to}", {27'd0, busy_b, pass_b, idm_b, tsm_b, to_b},
            {27'd0, 1'b0, e.pass, e.idm, e.tsm, e.to});
        chk("B id_value", idv_b, e.id);
        chk("B ts_value", tsv_b, e.ts);
      end
    end
  end

  task automatic wait_empty(input bit is_b);
    for (int i = 0; i < 40; i++) begin
      if ((is_b ? q_b.size() : q_a.size()) == 0) break;
      @(negedge clk);
    end
    if ((is_b ? q_b.size() : q_a.size()) != 0) begin
      chk(is_b ? "B done never arrived" : "A done never arrived", 32'd0, 32'd1);
      if (is_b) q_b.delete(); else q_a.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_zero_a(input string nm);
    chk(nm, {22'd0, busy_a, done_a, pass_a, idm_a, tsm_a, to_a, read_a, addr_a, 2'd0}, 32'd0);
    chk(nm, idv_a | tsv_a, 32'd0);
  endtask

  task automatic chk_zero_b(input string nm);
    chk(nm, {22'd0, busy_b, done_b, pass_b, idm_b, tsm_b, to_b, read_b, addr_b, 2'd0}, 32'd0);
    chk(nm, idv_b | tsv_b, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    int n;
    logic [1:0] rw_b[12];
    rw_b = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00,
             2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0; wr_a = 1'b0;
    slv_id_a = 32'hACD51302; slv_ts_a = 32'h571256B6;
    repeat (3) @(negedge clk);
    chk_zero_a("A reset state");
    chk_zero_b("B reset state");
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // A: nominal run, reads in cycles 1 and 2, done in cycle 3.
    c = cyc; start_a = 1'b1;
    q_a.push_back(mk(32'hACD51302, 32'h571256B6, 1'b1, 1'b1, 1'b1, 1'b0, c + 3));
    @(negedge clk); start_a = 1'b0;
    chk("A cycle1 {read,addr}", {30'd0, read_a, addr_a}, 32'b10);
    @(negedge clk);
    chk("A cycle2 {read,addr}", {30'd0, read_a, addr_a}, 32'b11);
    wait_empty(1'b0);

    // A: ID off by one in the LSB.
    slv_id_a = 32'hACD51303;
    c = cyc; start_a = 1'b1;
    q_a.push_back(mk(32'hACD51303, 32'h571256B6, 1'b0, 1'b0, 1'b1, 1'b0, c + 3));
    @(negedge clk); start_a = 1'b0;
    wait_empty(1'b0);
    slv_id_a = 32'hACD51302;

    // A: waitrequest stuck high, abort after 4 stall cycles.
    wr_a = 1'b1;
    c = cyc; start_a = 1'b1;
    q_a.push_back(mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, c + 5));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); start_a = 1'b0;
      chk("A stalled read held", {30'd0, read_a, addr_a}, 32'b10);
    end
    @(negedge clk);
    chk("A read dropped on timeout", {31'd0, read_a}, 32'd0);
    wait_empty(1'b0);
    wr_a = 1'b0;

    // A: start re-pulsed while busy and in the DONE cycle is ignored.
    n = dones_a;
    c = cyc; start_a = 1'b1;
    q_a.push_back(mk(32'hACD51302, 32'h571256B6, 1'b1, 1'b1, 1'b1, 1'b0, c + 3));
    @(negedge clk);
    @(negedge clk); start_a = 1'b0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (6) @(negedge clk);
    chk("A done count after ignored starts", 32'(dones_a), 32'(n + 1));
    chk("A idle after ignored starts", {31'd0, busy_a}, 32'd0);

    // A: later start clears held results and reruns.
    c = cyc; start_a = 1'b1;
    q_a.push_back(mk(32'hACD51302, 32'h571256B6, 1'b1, 1'b1, 1'b1, 1'b0, c + 3));
    @(negedge clk); start_a = 1'b0;
    chk("A results cleared on start", {28'd0, busy_a, pass_a, idm_a, tsm_a}, 32'b1000);
    chk("A id_value cleared on start", idv_a, 32'd0);
    wait_empty(1'b0);

    // B: 3 stall cycles per read, 2-cycle latency, done in cycle 13.
    c = cyc; start_b = 1'b1;
    q_b.push_back(mk(32'hACD51302, 32'h571256B6, 1'b1, 1'b1, 1'b1, 1'b0, c + 13));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); start_b = 1'b0;
      chk("B {read,addr} sequence", {30'd0, read_b, addr_b}, {30'd0, rw_b[k]});
    end
    wait_empty(1'b1);

    // B: reset in the LAT_TS cycle kills the run with no done.
    n = dones_b;
    start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    repeat (10) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk_zero_b("B outputs after mid-run reset");
    rst_b = 1'b0;
    repeat (15) @(negedge clk);
    chk("B no done after reset", 32'(dones_b), 32'(n));

    c = cyc; start_b = 1'b1;
    q_b.push_back(mk(32'hACD51302, 32'h571256B6, 1'b1, 1'b1, 1'b1, 1'b0, c + 13));
    @(negedge clk); start_b = 1'b0;
    wait_empty(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sysid_qsys_reader.md
Name: sysid_qsys_reader

Overview:
- Avalon-MM read master that fetches the two words of a system-ID slave on request.
  - Address 0 holds the system ID; address 1 holds the build timestamp.
- Compares both words against expected values and reports pass/fail.
- Sits beside the HPS bridge on the FPGA fabric side, so hardware/software mismatch is flagged before software touches other peripherals.

Parameters:
- EXPECTED_ID, 32'hACD51302, value required at address 0.
- EXPECTED_TS, 32'h571256B6, value required at address 1.
- READ_LATENCY, 0, fixed slave read latency in cycles (0..7). 0 means readdata is valid in the accept cycle.
- TIMEOUT_CYCLES, 255, maximum consecutive waitrequest cycles per read before abort (1..65535).

Ports:
- clock  in  1  single clock domain.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to run a check; honoured only when idle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of run (normal or timeout).
- pass  out  1  id_match & ts_match & !timeout; held until next accepted start.
- id_match  out  1  captured ID == EXPECTED_ID; held.
- ts_match  out  1  captured timestamp == EXPECTED_TS; held.
- timeout  out  1  run aborted on waitrequest timeout; held.
- id_value  out  32  captured address-0 word; held.
- ts_value  out  32  captured address-1 word; held.
- avm_address  out  1  word address to the slave.
- avm_read  out  1  read request.
- avm_readdata  in  32  slave read data.
- avm_waitrequest  in  1  slave stall. Tie to 0 for a zero-wait slave.

Behaviour:
- Reset: every output is 0. FSM goes to IDLE; wait and latency counters clear. Reset asserted mid-run overrides everything: avm_read is 0 from the next edge, and no done pulse is produced.
- FSM states: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE.
- IDLE:
  - start=1 at an edge → RD_ID.
  - At that edge: clear id_match, ts_match, pass, timeout, id_value, ts_value; set busy.
- RD_ID: drive avm_read=1, avm_address=0.
  - Accept is the edge with avm_waitrequest=0.
  - READ_LATENCY=0: capture avm_readdata into id_value at accept, then go to RD_TS.
  - READ_LATENCY>0: go to LAT_ID with avm_read=0.
- LAT_ID: count READ_LATENCY cycles, then capture readdata at the edge exactly READ_LATENCY cycles after accept → RD_TS.
- RD_TS / LAT_TS: identical to RD_ID / LAT_ID with avm_address=1; the capture goes to ts_value.
- Outside RD_ID and RD_TS: avm_read=0 and avm_address=0.
- Compare and DONE:
  - id_match and ts_match are registered from the captured words and are valid by the DONE cycle.
  - DONE lasts one cycle: done=1, busy=0, pass valid → IDLE.
- Timeout:
  - The wait counter increments on each edge where avm_read=1 and avm_waitrequest=1. It clears on accept and on entry to each RD state.
  - When the count reaches TIMEOUT_CYCLES: timeout=1, avm_read=0, pass=0, and jump to DONE. The value for the aborted read stays 0.
- start while busy, or in the DONE cycle: ignored and not queued.
- Timing, READ_LATENCY=0, no waitrequest, start at edge 0:
  - Read of address 0 in cycle 1.
  - Read of address 1 in cycle 2.
  - done=1 in cycle 3.
  - Each waitrequest cycle or latency cycle adds one cycle.
- Comparisons are full 32-bit equality; there is no masking.

Test Plan:
- Zero-wait slave returning 32'hACD51302 / 32'h571256B6, READ_LATENCY=0, start pulse at cycle 0:
  - avm_read high in cycles 1–2 with address 0 then 1.
  - done pulse in cycle 3 with pass=1, id_match=1, ts_match=1.
  - id_value=ACD51302, ts_value=571256B6.
- Slave returns 32'hACD51303 at address 0 → done with id_match=0, ts_match=1, pass=0, id_value=ACD51303.
- waitrequest held 3 cycles on each read, READ_LATENCY=2:
  - Reads stay asserted while stalled, with the address stable.
  - Data is captured 2 cycles after accept.
  - done in cycle 13; pass=1.
- TIMEOUT_CYCLES=4 with waitrequest stuck high → after 4 stall cycles avm_read drops, done pulses, timeout=1, pass=0, id_value=0.
- start re-pulsed while busy, and in the DONE cycle → no second run, no extra done. A later start in IDLE clears the previous results and reruns.
- reset asserted in the LAT_TS cycle → avm_read=0, all outputs 0 next cycle, no done. A following start runs normally to pass=1.
